// File: rtl/vend_pkg.sv
// Shared types, default sizing and helpers for the multi-item vending controller.
package vend_pkg;

  localparam int unsigned DEF_N_ITEMS     = 4;
  localparam int unsigned DEF_CREDIT_W    = 8;
  localparam int unsigned DEF_MAX_CREDIT  = 200;
  localparam int unsigned PRICE_TBL_MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CREDIT = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_e;

  // Extracts entry idx of width w from a packed price table (w <= 32).
  function automatic logic [31:0] price_slice(input logic [PRICE_TBL_MAX_W-1:0] tbl,
                                              input int unsigned idx,
                                              input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return 32'(tbl >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/multi_item_vending_ctrl_if.sv
// Front-end / mechanics handshake bundle for the vending controller.
interface multi_item_vending_ctrl_if #(
  parameter int unsigned N_ITEMS  = vend_pkg::DEF_N_ITEMS,
  parameter int unsigned CREDIT_W = vend_pkg::DEF_CREDIT_W,
  parameter int unsigned SEL_W    = $clog2(N_ITEMS)
);

  logic                        coin_valid;
  logic [CREDIT_W-1:0]         coin_value;
  logic                        buy_valid;
  logic [SEL_W-1:0]            buy_sel;
  logic                        cancel;
  logic [N_ITEMS*CREDIT_W-1:0] prices;
  logic                        vend_valid;
  logic [SEL_W-1:0]            vend_item;
  logic                        vend_ack;
  logic                        change_valid;
  logic [CREDIT_W-1:0]         change_amount;
  logic                        change_ack;
  logic [CREDIT_W-1:0]         credit;
  logic                        coin_reject;
  logic                        buy_reject;

  // Front end / mechanics side.
  modport master (
    output coin_valid, coin_value, buy_valid, buy_sel, cancel, prices,
           vend_ack, change_ack,
    input  vend_valid, vend_item, change_valid, change_amount, credit,
           coin_reject, buy_reject
  );

  // Controller side.
  modport slave (
    input  coin_valid, coin_value, buy_valid, buy_sel, cancel, prices,
           vend_ack, change_ack,
    output vend_valid, vend_item, change_valid, change_amount, credit,
           coin_reject, buy_reject
  );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit register with ceiling-checked add, subtract and clear.
module vend_credit_acc #(
  parameter int unsigned CREDIT_W   = vend_pkg::DEF_CREDIT_W,
  parameter int unsigned MAX_CREDIT = vend_pkg::DEF_MAX_CREDIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add_en_i,
  input  logic [CREDIT_W-1:0] add_val_i,
  input  logic                sub_en_i,
  input  logic [CREDIT_W-1:0] sub_val_i,
  input  logic                clr_i,
  output logic                add_ok_c_o,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SUM_W-1:0]    sum_c;

  // One extra bit so the ceiling check never sees a wrapped sum.
  assign sum_c      = {1'b0, credit_q} + {1'b0, add_val_i};
  assign add_ok_c_o = (sum_c <= SUM_W'(MAX_CREDIT));

  always_comb begin
    credit_d = credit_q;
    if (clr_i) begin
      credit_d = '0;
    end else if (add_en_i && add_ok_c_o) begin
      credit_d = sum_c[CREDIT_W-1:0];
    end else if (sub_en_i) begin
      credit_d = credit_q - sub_val_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/multi_item_vending_ctrl.sv
// Multi-product vending controller: credit accumulation, priced selection, vend/change handshakes.
module multi_item_vending_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned N_ITEMS    = DEF_N_ITEMS,
  parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned SEL_W      = $clog2(N_ITEMS)
) (
  input logic                      clk,
  input logic                      rst_n,
  multi_item_vending_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_item_q, vend_item_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                coin_reject_q, coin_reject_d;
  logic                buy_reject_q, buy_reject_d;

  logic                add_en_c, sub_en_c, clr_c, add_ok_c, buy_ok_c;
  logic [CREDIT_W-1:0] credit_c, price_c;

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_en_i   (add_en_c),
    .add_val_i  (bus.coin_value),
    .sub_en_i   (sub_en_c),
    .sub_val_i  (price_c),
    .clr_i      (clr_c),
    .add_ok_c_o (add_ok_c),
    .credit_o   (credit_c)
  );

  assign price_c  = CREDIT_W'(price_slice(PRICE_TBL_MAX_W'(bus.prices), 32'(bus.buy_sel), CREDIT_W));
  assign buy_ok_c = (32'(bus.buy_sel) < N_ITEMS) && (price_c <= credit_c);

  // Next state and registered outputs; coin beats cancel beats buy.
  always_comb begin
    state_d         = state_q;
    vend_valid_d    = vend_valid_q;
    vend_item_d     = vend_item_q;
    change_valid_d  = change_valid_q;
    change_amount_d = change_amount_q;
    coin_reject_d   = 1'b0;
    buy_reject_d    = 1'b0;
    add_en_c        = 1'b0;
    sub_en_c        = 1'b0;
    clr_c           = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.coin_valid) begin
          if (add_ok_c) begin
            add_en_c = 1'b1;
            if (bus.coin_value != '0) begin
              state_d = ST_CREDIT;
            end
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (bus.cancel) begin
          if (state_q == ST_CREDIT) begin
            change_valid_d  = 1'b1;
            change_amount_d = credit_c;
            state_d         = ST_CHANGE;
          end
        end else if (bus.buy_valid) begin
          if (buy_ok_c) begin
            sub_en_c     = 1'b1;
            vend_item_d  = bus.buy_sel;
            vend_valid_d = 1'b1;
            state_d      = ST_VEND;
          end else begin
            buy_reject_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = bus.coin_valid;
        buy_reject_d  = bus.buy_valid;
        if (bus.vend_ack && vend_valid_q) begin
          vend_valid_d = 1'b0;
          // Leftover credit is always refunded; change starts with no dead cycle.
          if (credit_c != '0) begin
            change_valid_d  = 1'b1;
            change_amount_d = credit_c;
            state_d         = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        buy_reject_d  = bus.buy_valid;
        if (bus.change_ack && change_valid_q) begin
          change_valid_d = 1'b0;
          clr_c          = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      vend_valid_q    <= 1'b0;
      vend_item_q     <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      buy_reject_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      vend_valid_q    <= vend_valid_d;
      vend_item_q     <= vend_item_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      coin_reject_q   <= coin_reject_d;
      buy_reject_q    <= buy_reject_d;
    end
  end

  assign bus.vend_valid    = vend_valid_q;
  assign bus.vend_item     = vend_item_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;
  assign bus.credit        = credit_c;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.buy_reject    = buy_reject_q;

endmodule

// File: tb/tb_multi_item_vending_ctrl.sv
// Scoreboard bench for multi_item_vending_ctrl with prices {30,50,100,150}, ceiling 200.
module tb_multi_item_vending_ctrl;

  localparam int unsigned N_ITEMS  = 4;
  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned SEL_W    = 2;
  localparam logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd150, 8'd100, 8'd50, 8'd30};

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   exp_vend[$];
  int   exp_chg[$];
  bit   vv_prev;
  bit   cv_prev;

  multi_item_vending_ctrl_if #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .SEL_W(SEL_W)) bus ();

  multi_item_vending_ctrl #(
    .N_ITEMS    (N_ITEMS),
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (200),
    .SEL_W      (SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each rising valid must match the oldest expected payload.
  always @(negedge clk) begin
    int e;
    if (bus.vend_valid && !vv_prev) begin
      tests++;
      if (exp_vend.size() == 0) begin
        fails++;
        $display("FAIL vend_unexpected: got item %0d, expected no vend", bus.vend_item);
      end else begin
        e = exp_vend.pop_front();
        if (bus.vend_item !== 2'(e)) begin
          fails++;
          $display("FAIL vend_item: got %0d, expected %0d", bus.vend_item, e);
        end
      end
    end
    if (bus.change_valid && !cv_prev) begin
      tests++;
      if (exp_chg.size() == 0) begin
        fails++;
        $display("FAIL change_unexpected: got %0d, expected no change", bus.change_amount);
      end else begin
        e = exp_chg.pop_front();
        if (bus.change_amount !== 8'(e)) begin
          fails++;
          $display("FAIL change_amount: got %0d, expected %0d", bus.change_amount, e);
        end
      end
    end
    vv_prev = bus.vend_valid;
    cv_prev = bus.change_valid;
  end

  task automatic coin(input int v);
    @(negedge clk);
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'(v);
    @(negedge clk);
    bus.coin_valid = 1'b0;
  endtask

  task automatic buy(input int s);
    @(negedge clk);
    bus.buy_valid = 1'b1;
    bus.buy_sel   = 2'(s);
    @(negedge clk);
    bus.buy_valid = 1'b0;
  endtask

  task automatic cancel_req();
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
  endtask

  task automatic vend_ack_pulse();
    @(negedge clk);
    bus.vend_ack = 1'b1;
    @(negedge clk);
    bus.vend_ack = 1'b0;
  endtask

  task automatic change_ack_pulse();
    @(negedge clk);
    bus.change_ack = 1'b1;
    @(negedge clk);
    bus.change_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.vend_valid, bus.change_valid, bus.coin_reject, bus.buy_reject} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 0000",
               {bus.vend_valid, bus.change_valid, bus.coin_reject, bus.buy_reject});
    end
    tests++;
    if (bus.credit !== 8'd0 || bus.vend_item !== 2'd0 || bus.change_amount !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: credit %0d item %0d change %0d, expected all 0",
               bus.credit, bus.vend_item, bus.change_amount);
    end
  endtask

  task automatic test_exact_buy();
    coin(50);
    tests++;
    if (bus.credit !== 8'd50) begin fails++; $display("FAIL exact_credit1: got %0d, expected 50", bus.credit); end
    coin(50);
    tests++;
    if (bus.credit !== 8'd100) begin fails++; $display("FAIL exact_credit2: got %0d, expected 100", bus.credit); end
    exp_vend.push_back(2);
    buy(2);
    tests++;
    if (bus.vend_valid !== 1'b1 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL exact_vend: vend_valid %b credit %0d, expected 1 and 0", bus.vend_valid, bus.credit);
    end
    vend_ack_pulse();
    tests++;
    if (bus.vend_valid !== 1'b0 || bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL exact_done: vend %b change %b credit %0d, expected 0 0 0",
               bus.vend_valid, bus.change_valid, bus.credit);
    end
  endtask

  task automatic test_change();
    coin(100);
    coin(50);
    exp_vend.push_back(0);
    exp_chg.push_back(120);
    buy(0);
    tests++;
    if (bus.credit !== 8'd120) begin fails++; $display("FAIL change_credit: got %0d, expected 120", bus.credit); end
    vend_ack_pulse();
    tests++;
    if (bus.vend_valid !== 1'b0 || bus.change_valid !== 1'b1) begin
      fails++;
      $display("FAIL change_handoff: vend %b change %b, expected 0 1", bus.vend_valid, bus.change_valid);
    end
    change_ack_pulse();
    tests++;
    if (bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL change_done: change %b credit %0d, expected 0 0", bus.change_valid, bus.credit);
    end
  endtask

  task automatic test_overflow();
    coin(150);
    coin(100);
    tests++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd150) begin
      fails++;
      $display("FAIL ovf_reject: reject %b credit %0d, expected 1 150", bus.coin_reject, bus.credit);
    end
    @(negedge clk);
    tests++;
    if (bus.coin_reject !== 1'b0) begin fails++; $display("FAIL ovf_pulse_len: got %b, expected 0", bus.coin_reject); end
    coin(50);
    tests++;
    if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd200) begin
      fails++;
      $display("FAIL ovf_ceiling: reject %b credit %0d, expected 0 200", bus.coin_reject, bus.credit);
    end
    exp_chg.push_back(200);
    cancel_req();
    change_ack_pulse();
  endtask

  task automatic test_buy_reject();
    coin(40);
    buy(1);
    tests++;
    if (bus.buy_reject !== 1'b1 || bus.credit !== 8'd40 || bus.vend_valid !== 1'b0) begin
      fails++;
      $display("FAIL rej_price: reject %b credit %0d vend %b, expected 1 40 0",
               bus.buy_reject, bus.credit, bus.vend_valid);
    end
    buy(3);
    tests++;
    if (bus.buy_reject !== 1'b1 || bus.credit !== 8'd40) begin
      fails++;
      $display("FAIL rej_item3: reject %b credit %0d, expected 1 40", bus.buy_reject, bus.credit);
    end
    exp_chg.push_back(40);
    cancel_req();
    tests++;
    if (bus.change_valid !== 1'b1) begin fails++; $display("FAIL rej_cancel: change %b, expected 1", bus.change_valid); end
    change_ack_pulse();
  endtask

  task automatic test_priority();
    coin(30);
    @(negedge clk);
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd10;
    bus.buy_valid  = 1'b1;
    bus.buy_sel    = 2'd0;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    bus.buy_valid  = 1'b0;
    tests++;
    if (bus.credit !== 8'd40 || bus.vend_valid !== 1'b0 || bus.buy_reject !== 1'b0) begin
      fails++;
      $display("FAIL prio_coin_buy: credit %0d vend %b reject %b, expected 40 0 0",
               bus.credit, bus.vend_valid, bus.buy_reject);
    end
    exp_vend.push_back(0);
    buy(0);
    coin(20);
    tests++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd10 || bus.vend_valid !== 1'b1) begin
      fails++;
      $display("FAIL prio_coin_in_vend: reject %b credit %0d vend %b, expected 1 10 1",
               bus.coin_reject, bus.credit, bus.vend_valid);
    end
    buy(1);
    tests++;
    if (bus.buy_reject !== 1'b1) begin fails++; $display("FAIL prio_buy_in_vend: got %b, expected 1", bus.buy_reject); end
    exp_chg.push_back(10);
    vend_ack_pulse();
    change_ack_pulse();
    tests++;
    if (bus.credit !== 8'd0) begin fails++; $display("FAIL prio_end_credit: got %0d, expected 0", bus.credit); end
  endtask

  task automatic test_reset_mid();
    coin(60);
    exp_chg.push_back(60);
    cancel_req();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.change_valid !== 1'b0 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL rst_async: change %b vend %b credit %0d, expected 0 0 0",
               bus.change_valid, bus.vend_valid, bus.credit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vend_ack_pulse();
    change_ack_pulse();
    tests++;
    if (bus.change_valid !== 1'b0 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL rst_stale_ack: change %b vend %b credit %0d, expected 0 0 0",
               bus.change_valid, bus.vend_valid, bus.credit);
    end
    coin(10);
    tests++;
    if (bus.credit !== 8'd10) begin fails++; $display("FAIL rst_recover: got %0d, expected 10", bus.credit); end
    exp_chg.push_back(10);
    cancel_req();
    change_ack_pulse();
  endtask

  task automatic test_back_to_back();
    coin(20);
    exp_chg.push_back(20);
    cancel_req();
    @(negedge clk);
    bus.change_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin
      fails++;
      $display("FAIL b2b_ack: change %b credit %0d, expected 0 0", bus.change_valid, bus.credit);
    end
    bus.coin_valid = 1'b1;
    bus.coin_value = 8'd30;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    tests++;
    if (bus.credit !== 8'd30 || bus.change_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_coin: credit %0d change %b, expected 30 0", bus.credit, bus.change_valid);
    end
    @(negedge clk);
    bus.change_ack = 1'b0;
    exp_chg.push_back(30);
    cancel_req();
    change_ack_pulse();
    coin(0);
    tests++;
    if (bus.credit !== 8'd0 || bus.coin_reject !== 1'b0) begin
      fails++;
      $display("FAIL zero_coin: credit %0d reject %b, expected 0 0", bus.credit, bus.coin_reject);
    end
    bus.prices = {8'd150, 8'd100, 8'd50, 8'd0};
    exp_vend.push_back(0);
    buy(0);
    tests++;
    if (bus.vend_valid !== 1'b1 || bus.buy_reject !== 1'b0) begin
      fails++;
      $display("FAIL free_vend: vend %b reject %b, expected 1 0", bus.vend_valid, bus.buy_reject);
    end
    vend_ack_pulse();
    tests++;
    if (bus.vend_valid !== 1'b0 || bus.change_valid !== 1'b0) begin
      fails++;
      $display("FAIL free_done: vend %b change %b, expected 0 0", bus.vend_valid, bus.change_valid);
    end
    bus.prices = PRICES;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.buy_valid  = 1'b0;
    bus.buy_sel    = '0;
    bus.cancel     = 1'b0;
    bus.prices     = PRICES;
    bus.vend_ack   = 1'b0;
    bus.change_ack = 1'b0;

    test_reset();
    test_exact_buy();
    test_change();
    test_overflow();
    test_buy_reject();
    test_priority();
    test_reset_mid();
    test_back_to_back();

    repeat (2) @(negedge clk);
    tests++;
    if (exp_vend.size() != 0 || exp_chg.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d vends and %0d changes never seen, expected 0 0",
               exp_vend.size(), exp_chg.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_item_vending_ctrl.md
# multi_item_vending_ctrl

Parametrised vending controller: a successor to the single-product coffee FSM. It accumulates a multi-denomination credit, sells one of N_ITEMS products at runtime-programmable prices, and hands off to a dispenser and a change unit with valid/ack handshakes. It sits between the coin acceptor/keypad front end and the dispense/change mechanics.

## Interface
- N_ITEMS, 4: number of selectable products; must be ≥ 2.
- CREDIT_W, 8: width of the credit, price and coin value, in money units.
- MAX_CREDIT, 200: credit ceiling; must be < 2**CREDIT_W.
- SEL_W, $clog2(N_ITEMS): width of the item select.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  one-cycle coin insertion strobe.
- coin_value  in  CREDIT_W  value of the inserted coin; 0 is legal and ignored.
- buy_valid  in  1  one-cycle purchase request.
- buy_sel  in  SEL_W  requested item index.
- cancel  in  1  one-cycle request to refund the credit.
- prices  in  N_ITEMS*CREDIT_W  price table; item i is at bits [i*CREDIT_W +: CREDIT_W]; static while not IDLE.
- vend_valid  out  1  dispense request; held until acknowledged.
- vend_item  out  SEL_W  item to dispense; stable while vend_valid.
- vend_ack  in  1  dispenser done.
- change_valid  out  1  refund request; held until acknowledged.
- change_amount  out  CREDIT_W  refund value; stable while change_valid.
- change_ack  in  1  change paid.
- credit  out  CREDIT_W  current credit register.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- buy_reject  out  1  one-cycle pulse when a purchase is refused.

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE. Encoding is 2 bits: 00, 01, 10, 11.
- **Coin in IDLE/CREDIT:**
  - If credit+coin_value ≤ MAX_CREDIT, add it to credit and go to CREDIT (stay in IDLE if the value is 0).
  - Otherwise pulse coin_reject and leave credit unchanged.
  - Compute the sum at CREDIT_W+1 bits; there is no wrap.
- **Coin in VEND/CHANGE:** always pulse coin_reject.
- **Buy in IDLE/CREDIT:**
  - Accept when buy_sel < N_ITEMS and price[buy_sel] ≤ credit.
  - On accept: credit -= price, vend_item <= buy_sel, vend_valid <= 1, go to VEND.
  - Otherwise pulse buy_reject; state and credit unchanged.
  - A price of 0 is a free vend and is legal from IDLE.
- **Buy in VEND/CHANGE:** pulse buy_reject.
- **Priority within one cycle:** coin > cancel > buy.
  - A buy that loses to a coin or cancel is dropped silently, with no buy_reject.
  - Cancel and coin in the same cycle: the coin is added first; cancel is ignored.
- **Cancel:**
  - In CREDIT: change_amount <= credit, change_valid <= 1, go to CHANGE.
  - In IDLE, VEND or CHANGE: ignored.
- **VEND:** on vend_ack, clear vend_valid. Then go to CHANGE with change_amount = credit if credit > 0, else go to IDLE. No multi-purchase: leftover credit is always refunded.
- **CHANGE:** on change_ack, clear change_valid, set credit to 0, go to IDLE.
- An ack while the matching valid is low is ignored.

## Timing
- Reset values: all outputs 0, credit 0, state IDLE. Reset mid-VEND or mid-CHANGE drops both valids immediately (asynchronously) and loses the credit.
- All outputs are registered.
- vend_valid, change_valid and credit update on the edge that samples the causing input, so they are visible 1 cycle after the request.
- coin_reject and buy_reject are high for exactly the cycle after the offending strobe.
- vend_ack sampled high → vend_valid low next cycle. When the leftover credit is > 0, change_valid rises in that same cycle, so there is no dead cycle between the two handshakes.
- change_ack sampled high → change_valid low and credit 0 next cycle; a new coin is accepted in that cycle.
- Ack held high for several cycles counts once. The next transaction needs a fresh valid.

## Structure
- Package vend_pkg holds:
  - the state typedef and encodings;
  - the default N_ITEMS, CREDIT_W and MAX_CREDIT;
  - a price-slice function.
- One sub-module, vend_credit_acc, does the saturating-check add and subtract and holds the credit register. The FSM and handshake logic stay in the top module.

## Test plan
Common setup: prices {30, 50, 100, 150}, MAX_CREDIT 200.
- Coins 50, 50, then buy item 2 → credit reads 50, then 100; vend_valid with vend_item=2; ack → IDLE, credit 0, no change_valid.
- Coins 100, 50, buy item 0 → vend item 0; vend_ack → change_valid with change_amount=120 in the cycle vend_valid falls; change_ack → credit 0.
- Coin 150, then coin 100 → coin_reject pulse for 1 cycle; credit stays 150.
- Credit 40, buy item 1 → buy_reject; credit 40. Then buy_sel=3 with credit 40 → buy_reject. Then cancel → change_amount=40.
- Same-cycle coin 10 + buy item 0 with credit 30 → credit 40, no vend, no buy_reject. Coin during VEND → coin_reject; credit unchanged.
- rst_n low while change_valid=1 → all outputs 0 immediately; vend_ack or change_ack after reset have no effect.
